diagonal_arbiter: RTL
=====================

DIAGONAL_ARBITER -- requirements
Module: diagonal_arbiter

Interface
REQ-001 SHALL have parameter: W, 4, width of coordinate registers X and Y.
REQ-002 SHALL have parameter: KMAX, all-ones of W bits (15), saturation limit of X.
REQ-003 SHALL have port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port: reset  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port: req  input  2  per-requester request; bit i is requester i.
REQ-006 SHALL have port: cmd0  input  2  requester 0 command, sampled only when requester 0 wins arbitration.
REQ-007 SHALL have port: cmd1  input  2  requester 1 command, sampled only when requester 1 wins arbitration.
REQ-008 SHALL have port: gnt  output  2  one-hot grant; 00 when no requester holds the datapath.
REQ-009 SHALL have port: ack  output  1  command accepted and applied; one-cycle pulse.
REQ-010 SHALL have port: nack  output  1  command rejected, X/Y unchanged; one-cycle pulse.
REQ-011 SHALL have port: X  output  W  shared X coordinate register.
REQ-012 SHALL have port: Y  output  W  shared Y coordinate register.
REQ-013 SHALL have port: busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, RESP; transitions are IDLE->EXEC when req!=00, EXEC->RESP always, RESP->IDLE always; IDLE holds when req==00.
REQ-015 SHALL arbitrate in IDLE round-robin: single request wins; if both request, winner = !rr, where rr is the 1-bit index of the last granted requester.
REQ-016 SHALL, on IDLE->EXEC, register the winner one-hot into gnt and latch the winner's command into cmd_q; gnt stays asserted through EXEC and RESP and clears on RESP->IDLE.
REQ-017 SHALL update rr to the granted index on RESP->IDLE.
REQ-018 SHALL apply cmd_q on the EXEC->RESP edge and assert exactly one of ack/nack for the RESP cycle only.
REQ-019 SHALL decode cmd 00 NOP: X, Y unchanged, ack.
REQ-020 SHALL decode cmd 01 INC_X: if X==KMAX then nack, else X<=X+1, ack.
REQ-021 SHALL decode cmd 10 INC_Y: if Y==X then nack, else Y<=Y+1, ack.
REQ-022 SHALL decode cmd 11 JUMP: J=(KMAX>>1)+(X>>1) in W bits; if J<Y then nack, else X<=J, ack.
REQ-023 SHALL never modify X or Y outside the EXEC->RESP edge or reset.
REQ-024 SHALL complete a granted command even if req drops during EXEC or RESP; req and cmd are ignored outside IDLE.
REQ-025 SHALL, under arithmetic rules, never wrap X or Y; every accepted command preserves X>=Y (unsigned).
REQ-026 SHALL set latency: req sampled at edge N in IDLE -> gnt after N, X/Y update and ack/nack after N+1, gnt low and IDLE after N+2; minimum 3 cycles per grant.
REQ-027 SHALL drive busy=1 in EXEC and RESP, 0 in IDLE.
REQ-028 SHALL contain formal assertions: !(X<Y) at all times; gnt is one-hot or zero; !(ack&&nack); (ack||nack) implies state RESP.

Reset
REQ-029 SHALL, when reset is high at a rising edge, force state=IDLE, X=0, Y=0, gnt=00, ack=0, nack=0, busy=0, rr=1, overriding any in-flight command (no ack/nack for it).
REQ-030 SHALL give all registers initial values equal to their reset values so formal runs start in the reset state.

Verification
REQ-031 SHALL be verified: reset, then req=01 cmd0=01 -> gnt=01 after 1 cycle, ack pulse after 2, X=1 Y=0, gnt=00 after 3.
REQ-032 SHALL be verified: from X=1,Y=0 issue INC_Y -> ack, Y=1; repeat INC_Y -> nack, X=1 Y=1 unchanged.
REQ-033 SHALL be verified: after reset req=11 held, cmd0=01, cmd1=01 -> grants alternate 01,10,01; X=3 after three grants, no back-to-back same requester.
REQ-034 SHALL be verified: X=15,Y=14: INC_X -> nack; JUMP -> ack, X=14. X=15,Y=15: JUMP -> nack, unchanged.
REQ-035 SHALL be verified: reset asserted during EXEC of INC_X from X=5,Y=2 -> next cycle X=0 Y=0 gnt=00 busy=0, no ack/nack pulse.
REQ-036 SHALL be verified: X=0,Y=0 JUMP -> ack, X=7 Y=0; property !(X<Y) proven unbounded by the formal flow.

Source files
------------

// File: rtl/diagonal_arbiter.sv
// Two-requester round-robin arbiter guarding a shared X/Y coordinate pair.
// A granted command runs IDLE -> EXEC -> RESP and keeps X >= Y at all times.
module diagonal_arbiter #(
    parameter int          W    = 4,
    parameter logic [W-1:0] KMAX = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   req,
    input  logic [1:0]   cmd0,
    input  logic [1:0]   cmd1,
    output logic [1:0]   gnt,
    output logic         ack,
    output logic         nack,
    output logic [W-1:0] X,
    output logic [W-1:0] Y,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    state_t       state_q = IDLE;
    state_t       state_d;
    logic [1:0]   gnt_q   = 2'b00;
    logic [1:0]   gnt_d;
    logic [1:0]   cmd_q   = 2'b00;
    logic [1:0]   cmd_d;
    logic         ack_q   = 1'b0;
    logic         ack_d;
    logic         nack_q  = 1'b0;
    logic         nack_d;
    logic [W-1:0] x_q     = '0;
    logic [W-1:0] x_d;
    logic [W-1:0] y_q     = '0;
    logic [W-1:0] y_d;
    logic         rr_q    = 1'b1;
    logic         rr_d;
    logic         win;
    logic [W-1:0] jump;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        cmd_d   = cmd_q;
        ack_d   = 1'b0;
        nack_d  = 1'b0;
        x_d     = x_q;
        y_d     = y_q;
        rr_d    = rr_q;
        // With both requesting, the one not granted last time wins.
        win     = (req == 2'b11) ? ~rr_q : req[1];
        jump    = (KMAX >> 1) + (x_q >> 1);
        unique case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    state_d = EXEC;
                    gnt_d   = win ? 2'b10 : 2'b01;
                    cmd_d   = win ? cmd1 : cmd0;
                end
            end
            EXEC: begin
                state_d = RESP;
                ack_d   = 1'b1;
                case (cmd_q)
                    2'b01: if (x_q == KMAX) ack_d = 1'b0; else x_d = x_q + ONE;
                    2'b10: if (y_q == x_q)  ack_d = 1'b0; else y_d = y_q + ONE;
                    2'b11: if (jump < y_q)  ack_d = 1'b0; else x_d = jump;
                    default: ;
                endcase
                nack_d = ~ack_d;
            end
            RESP: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
                rr_d    = gnt_q[1];
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            cmd_q   <= 2'b00;
            ack_q   <= 1'b0;
            nack_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            rr_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cmd_q   <= cmd_d;
            ack_q   <= ack_d;
            nack_q  <= nack_d;
            x_q     <= x_d;
            y_q     <= y_d;
            rr_q    <= rr_d;
        end
    end

    assign gnt  = gnt_q;
    assign ack  = ack_q;
    assign nack = nack_q;
    assign X    = x_q;
    assign Y    = y_q;
    assign busy = (state_q != IDLE);

    a_x_ge_y:    assert property (@(posedge clk) !(x_q < y_q));
    a_gnt_1hot:  assert property (@(posedge clk) $onehot0(gnt_q));
    a_resp_excl: assert property (@(posedge clk) !(ack_q && nack_q));
    a_resp_only: assert property (@(posedge clk) (ack_q || nack_q) |-> (state_q == RESP));

endmodule
